// File: rtl/gpio_bus_pkg.sv
// Shared encodings for the GPIO register-bus master: command ops, FSM states
// and the responder's register map.
package gpio_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        MODIFY = 2'b10,
        RESP   = 2'b11
    } state_e;

    localparam logic [7:0] REG_DATA = 8'h00;
    localparam logic [7:0] REG_DIR  = 8'h04;
    localparam logic [7:0] REG_IN   = 8'h08;

endpackage

// File: rtl/gpio_cmd_fifo.sv
// Show-ahead synchronous command FIFO; the head entry is visible on rdata
// whenever empty is low.
module gpio_cmd_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Full is taken from occupancy alone, so a same-cycle pop never opens a slot early.
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/gpio_reg_master.sv
// Register-bus initiator: queues host commands and runs each as a write, a read,
// or an atomic read-modify-write (SET/CLEAR), returning one response per command.
module gpio_reg_master
    import gpio_bus_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);
    localparam int FW = 2 + ADDR_W + DATA_W;

    logic [FW-1:0]     head;
    logic              fifo_full, fifo_empty, push, pop;
    state_e            state_q, state_d;
    op_e               cur_op_q, cur_op_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d;
    logic [DATA_W-1:0] rmw_q, rmw_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state_q == IDLE) && !fifo_empty;

    gpio_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({cmd_op, cmd_addr, cmd_wdata}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cur_op_d    = cur_op_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        rmw_d       = rmw_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    cur_op_d   = op_e'(head[FW-1 -: 2]);
                    cur_addr_d = head[DATA_W +: ADDR_W];
                    cur_data_d = head[DATA_W-1:0];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                case (cur_op_q)
                    OP_WRITE: begin rsp_rdata_d = cur_data_q; state_d = RESP; end
                    OP_READ:  begin rsp_rdata_d = rdata;      state_d = RESP; end
                    OP_SET:   begin rmw_d = rdata | cur_data_q;  state_d = MODIFY; end
                    OP_CLEAR: begin rmw_d = rdata & ~cur_data_q; state_d = MODIFY; end
                    default:  state_d = RESP;
                endcase
            end
            MODIFY: begin
                rsp_rdata_d = rmw_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_op_q    <= OP_WRITE;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            rmw_q       <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_op_q    <= cur_op_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            rmw_q       <= rmw_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Strobes come purely from registered state, so reset drops them immediately.
    assign wr_en     = ((state_q == ISSUE) && (cur_op_q == OP_WRITE)) || (state_q == MODIFY);
    assign rd_en     = (state_q == ISSUE) && (cur_op_q != OP_WRITE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign addr      = cur_addr_q;
    assign wdata     = (cur_op_q == OP_WRITE) ? cur_data_q : rmw_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gpio_reg_master.sv
// Directed bench for gpio_reg_master with a small GPIO register responder model
// (DATA/DIR writable, IN driven by the bench, unmapped reads return 0).
module tb_gpio_reg_master;
    import gpio_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_addr = 8'h00;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        busy, wr_en, rd_en;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;

    logic [31:0] reg_data = 32'h0, reg_dir = 32'h0, gpio_in = 32'h0;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, wr_cyc = 0, rd_cyc = 0;
    logic [7:0]  wr_addr = 8'h0, rd_addr = 8'h0;
    logic [31:0] wr_data = 32'h0;

    gpio_reg_master #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        rdata = 32'h0;
        case (addr)
            REG_DATA: rdata = reg_data;
            REG_DIR:  rdata = reg_dir;
            REG_IN:   rdata = gpio_in;
            default:  rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            case (addr)
                REG_DATA: reg_data <= wdata;
                REG_DIR:  reg_dir  <= wdata;
                default: ;
            endcase
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_addr <= addr;
            wr_data <= wdata;
        end
        if (rd_en) begin
            rd_cnt  <= rd_cnt + 1;
            rd_cyc  <= cyc;
            rd_addr <= addr;
        end
        if (wr_en && rd_en) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the index of the clock edge on which the command was accepted.
    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                        output int edge_idx);
        int k;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) chk("push_timeout", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        edge_idx = cyc - 1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] d);
        int k;
        @(negedge clk);
        rsp_ready = 1'b1;
        k = 0;
        while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
        d = rsp_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        int e, w0, r0, acc;
        logic [31:0] d;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_addr", {56'd0, addr}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        rst_n = 1'b1;

        // 1: plain write
        w0 = wr_cnt; r0 = rd_cnt;
        push(OP_WRITE, 8'h04, 32'h0000_00FF, e);
        get_rsp(d);
        chk("wr_rsp", {32'd0, d}, 64'hFF);
        chk("wr_count", 64'(wr_cnt - w0), 64'd1);
        chk("wr_no_rd", 64'(rd_cnt - r0), 64'd0);
        chk("wr_addr", {56'd0, wr_addr}, 64'h04);
        chk("wr_data", {32'd0, wr_data}, 64'hFF);
        chk("wr_latency", 64'(wr_cyc - e), 64'd2);
        chk("dir_reg", {32'd0, reg_dir}, 64'hFF);

        // 2: read of the input register
        gpio_in = 32'hA5A5_0F0F;
        w0 = wr_cnt; r0 = rd_cnt;
        push(OP_READ, 8'h08, 32'h0, e);
        get_rsp(d);
        chk("rd_rsp", {32'd0, d}, 64'hA5A5_0F0F);
        chk("rd_count", 64'(rd_cnt - r0), 64'd1);
        chk("rd_no_wr", 64'(wr_cnt - w0), 64'd0);
        chk("rd_latency", 64'(rd_cyc - e), 64'd2);

        // 3: SET then CLEAR on DATA
        push(OP_WRITE, 8'h00, 32'h10, e);
        get_rsp(d);
        chk("data_init", {32'd0, d}, 64'h10);
        w0 = wr_cnt; r0 = rd_cnt;
        push(OP_SET, 8'h00, 32'h3, e);
        get_rsp(d);
        chk("set_rsp", {32'd0, d}, 64'h13);
        chk("set_rd", 64'(rd_cnt - r0), 64'd1);
        chk("set_wr", 64'(wr_cnt - w0), 64'd1);
        chk("set_wdata", {32'd0, wr_data}, 64'h13);
        chk("set_order", 64'(wr_cyc - rd_cyc), 64'd1);
        chk("set_wr_addr", {56'd0, wr_addr}, 64'h00);
        push(OP_CLEAR, 8'h00, 32'h10, e);
        get_rsp(d);
        chk("clr_rsp", {32'd0, d}, 64'h03);
        push(OP_READ, 8'h00, 32'h0, e);
        get_rsp(d);
        chk("data_rb", {32'd0, d}, 64'h03);

        // 4: backpressure fills DEPTH + 1 in flight
        @(negedge clk);
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 8'h04;
            cmd_wdata = 32'h100 + 32'(acc);
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd5);
        chk("bp_full", {63'd0, cmd_ready}, 64'd0);
        chk("bp_rsp_stall", {63'd0, rsp_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            get_rsp(d);
            chk($sformatf("bp_rsp%0d", i), {32'd0, d}, 64'(32'h100 + i));
        end
        @(negedge clk);
        chk("bp_idle", {63'd0, busy}, 64'd0);
        chk("bp_ready", {63'd0, cmd_ready}, 64'd1);

        // 5: reset during MODIFY discards the pending write
        push(OP_SET, 8'h00, 32'h80, e);
        for (int k = 0; k < 20 && !rd_en; k++) @(negedge clk);
        @(posedge clk); #1;
        chk("in_modify", {63'd0, wr_en}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("arst_rd_en", {63'd0, rd_en}, 64'd0);
        chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt;
        repeat (10) @(negedge clk);
        chk("post_rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_no_wr", 64'(wr_cnt - w0), 64'd0);
        chk("post_rst_no_rd", 64'(rd_cnt - r0), 64'd0);
        chk("post_rst_data", {32'd0, reg_data}, 64'h03);

        // 6: unmapped read
        r0 = rd_cnt;
        push(OP_READ, 8'h0C, 32'h0, e);
        get_rsp(d);
        chk("unmapped_rsp", {32'd0, d}, 64'h0);
        chk("unmapped_addr", {56'd0, rd_addr}, 64'h0C);
        chk("unmapped_rd", 64'(rd_cnt - r0), 64'd1);

        chk("never_both", 64'(both_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
